// File: rtl/id_ex_stage_reg_if.sv
// ID/EX stage-register bus: decode-side inputs and the registered EX-side view.
// master = decode/hazard side (drives id_*, stall, flush), slave = the stage register.
interface id_ex_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  // hazard / flow control
  logic              stall;
  logic              flush;
  // decode side
  logic              id_valid;
  logic [1:0]        id_ctrl_wb;   // {regWrite, memToReg}
  logic [2:0]        id_ctrl_m;    // {branch, memRead, memWrite}
  logic [3:0]        id_ctrl_ex;   // {regDst, aluSrc, aluOp[1:0]}
  logic [DATA_W-1:0] id_pc4;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  // execute side
  logic              ex_valid;
  logic [1:0]        ex_ctrl_wb;
  logic [2:0]        ex_ctrl_m;
  logic              ex_regDst;
  logic              ex_aluSrc;
  logic [1:0]        ex_aluOp;
  logic [5:0]        ex_funcCode;
  logic [DATA_W-1:0] ex_pc4;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm;
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic [REG_AW-1:0] ex_rd;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output stall, flush, id_valid, id_ctrl_wb, id_ctrl_m, id_ctrl_ex,
           id_pc4, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
    input  ex_valid, ex_ctrl_wb, ex_ctrl_m, ex_regDst, ex_aluSrc, ex_aluOp,
           ex_funcCode, ex_pc4, ex_rs_data, ex_rt_data, ex_imm,
           ex_rs, ex_rt, ex_rd, bubble_cnt
  );

  modport slave (
    input  stall, flush, id_valid, id_ctrl_wb, id_ctrl_m, id_ctrl_ex,
           id_pc4, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
    output ex_valid, ex_ctrl_wb, ex_ctrl_m, ex_regDst, ex_aluSrc, ex_aluOp,
           ex_funcCode, ex_pc4, ex_rs_data, ex_rt_data, ex_imm,
           ex_rs, ex_rt, ex_rd, bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register of the 5-stage MIPS datapath.
// Priority each edge: reset > flush > stall > load. All outputs come straight
// from flops, so there is no input-to-output combinational path.
module id_ex_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic           clk,
  input  logic           reset,
  id_ex_stage_reg_if.slave bus
);

  logic              r_valid;
  logic [1:0]        r_ctrl_wb;
  logic [2:0]        r_ctrl_m;
  logic [3:0]        r_ctrl_ex;
  logic [5:0]        r_func;
  logic [DATA_W-1:0] r_pc4;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic [REG_AW-1:0] r_rd;
  logic [CNT_W-1:0]  r_bubble_cnt;

  logic              w_load;
  logic              w_nxt_valid;
  logic              w_cnt_sat;

  // A real load happens only when neither flush nor stall is asserted.
  assign w_load      = !bus.flush && !bus.stall;
  // Value ex_valid will take after this edge (reset handled in the flops).
  assign w_nxt_valid = bus.flush ? 1'b0 : (bus.stall ? r_valid : bus.id_valid);
  assign w_cnt_sat   = (r_bubble_cnt == {CNT_W{1'b1}});

  // Control groups and valid: a bubble (flush or id_valid=0) zeroes every
  // control bit so no regWrite/memRead/memWrite/branch can leak downstream.
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      r_valid   <= 1'b0;
      r_ctrl_wb <= '0;
      r_ctrl_m  <= '0;
      r_ctrl_ex <= '0;
    end else if (w_load) begin
      r_valid   <= bus.id_valid;
      r_ctrl_wb <= bus.id_valid ? bus.id_ctrl_wb : 2'b00;
      r_ctrl_m  <= bus.id_valid ? bus.id_ctrl_m  : 3'b000;
      r_ctrl_ex <= bus.id_valid ? bus.id_ctrl_ex : 4'b0000;
    end
  end

  // Data and specifier fields: captured on any load, even for a bubble, so
  // forwarding logic sees stable values; zeroed on reset and flush.
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      r_func    <= '0;
      r_pc4     <= '0;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm     <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
    end else if (w_load) begin
      r_func    <= bus.id_imm[5:0];
      r_pc4     <= bus.id_pc4;
      r_rs_data <= bus.id_rs_data;
      r_rt_data <= bus.id_rt_data;
      r_imm     <= bus.id_imm;
      r_rs      <= bus.id_rs;
      r_rt      <= bus.id_rt;
      r_rd      <= bus.id_rd;
    end
  end

  // Saturating count of edges that leave EX without a real instruction,
  // including stalled cycles that are holding a bubble.
  always_ff @(posedge clk) begin
    if (reset)
      r_bubble_cnt <= '0;
    else if (!w_nxt_valid && !w_cnt_sat)
      r_bubble_cnt <= r_bubble_cnt + 1'b1;
  end

  assign bus.ex_valid    = r_valid;
  assign bus.ex_ctrl_wb  = r_ctrl_wb;
  assign bus.ex_ctrl_m   = r_ctrl_m;
  assign bus.ex_regDst   = r_ctrl_ex[3];
  assign bus.ex_aluSrc   = r_ctrl_ex[2];
  assign bus.ex_aluOp    = r_ctrl_ex[1:0];
  assign bus.ex_funcCode = r_func;
  assign bus.ex_pc4      = r_pc4;
  assign bus.ex_rs_data  = r_rs_data;
  assign bus.ex_rt_data  = r_rt_data;
  assign bus.ex_imm      = r_imm;
  assign bus.ex_rs       = r_rs;
  assign bus.ex_rt       = r_rt;
  assign bus.ex_rd       = r_rd;
  assign bus.bubble_cnt  = r_bubble_cnt;

endmodule
